aes128_decrypt_iter: RTL and testbench

- Iterative AES-128 inverse cipher (FIPS-197 InvCipher); the decryption counterpart of the team's encryption datapath.
- Computes one round per clock over a single 128-bit state register.
- Round keys come precomputed from the existing key_expansion block as a flat 1408-bit bus.
- Valid/ready handshakes on both the ciphertext input and the plaintext output; one block in flight at a time.

---
 rtl/aes128_decrypt_iter.sv | 174 +++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock over a single 128-bit state register,
// with valid/ready handshakes on ciphertext in and plaintext out.

// One 32-bit word of inverse S-box lookups (four independent bytes).
module inv_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign new_sboxw[31:24] = INV_SBOX[sboxw[31:24]];
    assign new_sboxw[23:16] = INV_SBOX[sboxw[23:16]];
    assign new_sboxw[15:8]  = INV_SBOX[sboxw[15:8]];
    assign new_sboxw[7:0]   = INV_SBOX[sboxw[7:0]];
endmodule

module aes128_decrypt_iter #(
    parameter int unsigned NR = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [127:0]            cipher_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [128*(NR+1)-1:0]   round_keys,
    output logic [127:0]            plain_out,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam int unsigned N_RK  = 16;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [BLK_W-1:0] plain_q, plain_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [BLK_W-1:0] rk_c [N_RK];
    logic [BLK_W-1:0] sub_c, shift_c, ark_c, mix_c;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column multiply by {0e,0b,0d,09} built from x2/x4/x8 doublings.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Round-key table padded to the counter range so any rnd_q value selects a defined key.
    for (genvar i = 0; i < N_RK; i++) begin : g_rk
        if (i <= NR) begin : g_used
            assign rk_c[i] = round_keys[BLK_W*i +: BLK_W];
        end else begin : g_pad
            assign rk_c[i] = '0;
        end
    end

    for (genvar w = 0; w < 4; w++) begin : g_col
        inv_sbox u_inv_sbox (
            .sboxw     (state_q[BLK_W-1-32*w -: 32]),
            .new_sboxw (sub_c[BLK_W-1-32*w -: 32])
        );
        assign mix_c[BLK_W-1-32*w -: 32] = inv_mix_col(ark_c[BLK_W-1-32*w -: 32]);
    end

    // Row r rotates right by r: byte (r,c) takes (r,(c-r) mod 4).
    always_comb begin
        shift_c = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_c[BLK_W-1-8*(4*c+r) -: 8] = sub_c[BLK_W-1-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
    end

    assign ark_c = shift_c ^ rk_c[rnd_q];

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        plain_d     = plain_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (fsm_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    state_d    = cipher_in ^ rk_c[NR];
                    rnd_d      = RND_W'(NR - 1);
                    in_ready_d = 1'b0;
                    fsm_d      = ROUND;
                end
            end
            ROUND: begin
                in_ready_d = 1'b0;
                if (rnd_q == '0) begin
                    state_d     = ark_c;
                    plain_d     = ark_c;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    state_d = mix_c;
                    rnd_d   = rnd_q - RND_W'(1);
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            plain_q     <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            plain_q     <= plain_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign plain_out = plain_q;
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS-197 vectors, handshake corner cases and random blocks
// against a field-arithmetic model of InvCipher and the key schedule.
module tb_aes128_decrypt_iter;
    logic            clk = 1'b0;
    logic            reset;
    logic [127:0]    cipher_in;
    logic            in_valid;
    logic            in_ready;
    logic [1407:0]   round_keys;
    logic [127:0]    plain_out;
    logic            out_valid;
    logic            out_ready;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    aes128_decrypt_iter #(.NR(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .cipher_in  (cipher_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .round_keys (round_keys),
        .plain_out  (plain_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then the affine map.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] p = 8'h01;
            logic [7:0] s;
            for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
            s = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon = 8'h01;
        logic [1407:0] bus;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) bus[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return bus;
    endfunction

    function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic [1407:0] rkb);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rkb[1280 + 127 - 8*k -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = isb[s[4*((c-r+4)%4)+r]];
            for (int k = 0; k < 16; k++) t[k] = t[k] ^ rkb[128*rd + 127 - 8*k -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd > 0) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-r+4)%4], t[4*c+j]);
                        s[4*c+r] = acc;
                    end else begin
                        s[4*c+r] = t[4*c+r];
                    end
                end
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    task automatic send(input logic [127:0] ct);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_rdy", 128'(in_ready), 128'd1);
        in_valid  = 1'b1;
        cipher_in = ct;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic receive(input logic [127:0] exp, input string tag, input int hold);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'd10);
        check({tag, "_pt"}, plain_out, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 check({tag, "_hold"}, {plain_out ^ exp, 7'd0, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 check({tag, "_hs"}, 128'(out_valid), 128'd0);
    endtask

    task automatic wait_valid(output int t);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("wait_valid", 128'(out_valid), 128'd1);
        t = cyc;
    endtask

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [1407:0] rk_a, rk_b, rk_r;
        logic [127:0]  key_r, ct_r;
        int t0, ta, tb;
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        cipher_in  = '0;
        round_keys = '0;
        build_tables();
        rk_a = key_expand(KEY_A);
        rk_b = key_expand(KEY_B);

        // Reset held for three cycles, then release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_plain", plain_out, 128'd0);
        reset = 1'b1;
        #1 check("rel_in_ready_lo", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1 check("rel_in_ready_hi", 128'(in_ready), 128'd1);

        // FIPS-197 C.1 and appendix B.
        out_ready  = 1'b1;
        round_keys = rk_a;
        send(CT_A);
        receive(PT_A, "c1", 0);
        round_keys = rk_b;
        send(CT_B);
        receive(PT_B, "b", 0);

        // Backpressure with a rejected input pulse while the result waits.
        out_ready = 1'b0;
        send(CT_B);
        wait_valid(ta);
        check("bp_pt", plain_out, PT_B);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid  = i[0];
            cipher_in = CT_A;
            @(posedge clk);
            #1;
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_plain", plain_out, PT_B);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_valid", 128'(out_valid), 128'd0);
        check("bp_hs_in_ready", 128'(in_ready), 128'd1);
        repeat (14) @(posedge clk);
        #1 check("bp_not_captured", 128'(out_valid), 128'd0);

        // Back-to-back with in_valid held high.
        round_keys = rk_a;
        @(negedge clk);
        in_valid  = 1'b1;
        cipher_in = CT_A;
        @(posedge clk);
        #1;
        t0 = cyc;
        cipher_in = CT_B;
        wait_valid(ta);
        check("b2b_a_pt", plain_out, PT_A);
        check("b2b_a_lat", 128'(ta - t0), 128'd10);
        @(posedge clk);
        #1 round_keys = rk_b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("b2b_b_accept", 128'(in_ready), 128'd0);
        wait_valid(tb);
        check("b2b_b_pt", plain_out, PT_B);
        check("b2b_gap", 128'(tb - ta), 128'd12);
        @(posedge clk);
        #1 check("b2b_hs", 128'(out_valid), 128'd0);

        // Random blocks with random output stalls.
        for (int it = 0; it < 16; it++) begin
            int hold;
            key_r = {$urandom, $urandom, $urandom, $urandom};
            ct_r  = {$urandom, $urandom, $urandom, $urandom};
            rk_r  = key_expand(key_r);
            hold  = int'($urandom_range(0, 3));
            round_keys = rk_r;
            out_ready  = (hold == 0);
            send(ct_r);
            receive(inv_cipher(ct_r, rk_r), "rnd", hold);
        end

        // Abort in mid-flight, then rerun the same block.
        out_ready  = 1'b1;
        round_keys = rk_a;
        send(CT_A);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_valid", 128'(out_valid), 128'd0);
        check("abort_plain", plain_out, 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        send(CT_A);
        receive(PT_A, "rerun", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
